// File: rtl/time_display_scan_pkg.sv
// time_display_scan_pkg: shared constants for the 6-digit time display.
// Digit slots, field encoding and active-low 7-segment patterns (bit0 = a).
package time_display_scan_pkg;

    localparam logic [2:0] DIG_SEC_ONES  = 3'd0;
    localparam logic [2:0] DIG_SEC_TENS  = 3'd1;
    localparam logic [2:0] DIG_MIN_ONES  = 3'd2;
    localparam logic [2:0] DIG_MIN_TENS  = 3'd3;
    localparam logic [2:0] DIG_HOUR_ONES = 3'd4;
    localparam logic [2:0] DIG_HOUR_TENS = 3'd5;

    typedef enum logic [1:0] {
        F_NONE,
        F_SEC,
        F_MIN,
        F_HOUR
    } field_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    // Which time field a digit slot belongs to.
    function automatic field_t field_of_digit(input logic [2:0] idx);
        field_t f;
        unique case (idx)
            DIG_SEC_ONES, DIG_SEC_TENS:   f = F_SEC;
            DIG_MIN_ONES, DIG_MIN_TENS:   f = F_MIN;
            DIG_HOUR_ONES, DIG_HOUR_TENS: f = F_HOUR;
            default:                      f = F_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/time_display_scan_if.sv
// time_display_scan_if: time counts and set controls in, display drive out.
// master = time source / display board side, slave = scanner.
interface time_display_scan_if;

    logic [5:0] count_sec;
    logic [5:0] count_min;
    logic [5:0] count_hour;
    logic       load;
    logic       setting1;
    logic       setting2;
    logic       setting3;
    logic [5:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;

    modport master (
        output count_sec, count_min, count_hour,
        output load, setting1, setting2, setting3,
        input  an_n, seg_n, dp_n
    );

    modport slave (
        input  count_sec, count_min, count_hour,
        input  load, setting1, setting2, setting3,
        output an_n, seg_n, dp_n
    );

endinterface

// File: rtl/time_display_scan_seg7_decode.sv
// time_display_scan_seg7_decode: BCD digit + dash flag -> active-low segments.
// Ports: i_bcd (0..9), i_dash (show g only), o_seg (a..g, bit0 = a).
module time_display_scan_seg7_decode
    import time_display_scan_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_dash,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_dash) begin
            o_seg = SEG_DASH;
        end else begin
            case (i_bcd)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/time_display_scan.sv
// time_display_scan: scans hh:mm:ss onto a 6-digit common-anode display,
// blinking the field being set while load is high.
// Ports: clock, reset_n (async, active-low), bus (slave): counts and
// set controls in; an_n / seg_n / dp_n registered, active-low out.
// Build option DISP_12H_EN: 12-hour hours with PM dot on digit 5.
module time_display_scan
    import time_display_scan_pkg::*;
#(
    parameter int SCAN_DIV  = 25000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic               clock,
    input  logic               reset_n,
    time_display_scan_if.slave bus
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    logic [PW-1:0] r_presc, w_presc_nxt;
    logic [2:0]    r_idx, w_idx_nxt;
    logic [BW-1:0] r_bcnt, w_bcnt_nxt;
    logic          r_phase, w_phase_nxt;
    field_t        r_field, w_field_nxt;
    logic          r_first;
    logic [5:0]    r_sec, r_min, r_hour;
    logic [5:0]    w_sec, w_min, w_hour;
    logic          w_snap;
    field_t        w_dig_fld;
    logic [5:0]    w_val, w_disp;
    logic          w_dash, w_pm, w_blank;
    logic [3:0]    w_bcd;
    logic [6:0]    w_seg;
    logic [5:0]    w_an;
    logic          w_dp;
    logic [5:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    always_comb begin
        w_presc_nxt = r_presc + PW'(1);
        w_idx_nxt   = r_idx;
        if (r_presc == PW'(SCAN_DIV - 1)) begin
            w_presc_nxt = '0;
            w_idx_nxt   = (r_idx == DIG_HOUR_TENS) ? DIG_SEC_ONES
                                                   : r_idx + 3'd1;
        end
    end

    // Capture once per frame so all six digits agree.
    assign w_snap = r_first ||
                    (w_idx_nxt == DIG_SEC_ONES && r_idx != DIG_SEC_ONES);
    assign w_sec  = w_snap ? bus.count_sec  : r_sec;
    assign w_min  = w_snap ? bus.count_min  : r_min;
    assign w_hour = w_snap ? bus.count_hour : r_hour;

    always_comb begin
        w_field_nxt = r_field;
        w_bcnt_nxt  = r_bcnt;
        w_phase_nxt = r_phase;
        if (!bus.load) begin
            w_field_nxt = F_NONE;
            w_bcnt_nxt  = '0;
            w_phase_nxt = 1'b0;
        end else if (bus.setting1 || bus.setting2 || bus.setting3) begin
            priority case (1'b1)
                bus.setting3: w_field_nxt = F_HOUR;
                bus.setting2: w_field_nxt = F_MIN;
                default:      w_field_nxt = F_SEC;
            endcase
            w_bcnt_nxt  = '0;
            w_phase_nxt = 1'b0;
        end else if (r_field != F_NONE) begin
            if (r_bcnt == BW'(BLINK_DIV - 1)) begin
                w_bcnt_nxt  = '0;
                w_phase_nxt = ~r_phase;
            end else begin
                w_bcnt_nxt  = r_bcnt + BW'(1);
            end
        end
    end

    // Outputs are computed from next state so they line up with it.
    always_comb begin
        w_dig_fld = field_of_digit(w_idx_nxt);
        w_val     = w_hour;
        w_dash    = (w_hour > 6'd23);
        if (w_dig_fld == F_SEC) begin
            w_val  = w_sec;
            w_dash = (w_sec > 6'd59);
        end else if (w_dig_fld == F_MIN) begin
            w_val  = w_min;
            w_dash = (w_min > 6'd59);
        end
        w_disp = w_val;
        w_pm   = 1'b0;
`ifdef DISP_12H_EN
        if (w_dig_fld == F_HOUR && !w_dash) begin
            w_pm = (w_val >= 6'd12);
            if (w_val == 6'd0) begin
                w_disp = 6'd12;
            end else if (w_val > 6'd12) begin
                w_disp = w_val - 6'd12;
            end
        end
`endif
        w_bcd = w_idx_nxt[0] ? 4'(w_disp / 6'd10) : 4'(w_disp % 6'd10);
        w_blank = w_phase_nxt && (w_field_nxt == w_dig_fld);
        w_an = 6'h3F;
        // First cycle of each slot stays dark to stop ghosting.
        if (w_presc_nxt != '0 && !w_blank) begin
            w_an[w_idx_nxt] = 1'b0;
        end
        w_dp = 1'b1;
        if (w_idx_nxt == DIG_MIN_ONES || w_idx_nxt == DIG_HOUR_ONES ||
            (w_idx_nxt == DIG_HOUR_TENS && w_pm)) begin
            w_dp = 1'b0;
        end
    end

    time_display_scan_seg7_decode u_seg7 (
        .i_bcd  (w_bcd),
        .i_dash (w_dash),
        .o_seg  (w_seg)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_idx   <= DIG_SEC_ONES;
            r_first <= 1'b1;
            r_sec   <= '0;
            r_min   <= '0;
            r_hour  <= '0;
            r_an    <= 6'h3F;
            r_seg   <= SEG_BLANK;
            r_dp    <= 1'b1;
        end else begin
            r_presc <= w_presc_nxt;
            r_idx   <= w_idx_nxt;
            r_first <= 1'b0;
            r_sec   <= w_sec;
            r_min   <= w_min;
            r_hour  <= w_hour;
            r_an    <= w_an;
            r_seg   <= w_seg;
            r_dp    <= w_dp;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_field <= F_NONE;
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else begin
            r_field <= w_field_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    assign bus.an_n  = r_an;
    assign bus.seg_n = r_seg;
    assign bus.dp_n  = r_dp;

endmodule

// File: tb/tb_time_display_scan.sv
// tb_time_display_scan: randomized bench with a frame-level reference model.
// Scan, snapshot, dash, blink, priority, reset and 12h build checks.
module tb_time_display_scan;

    localparam int SD = 4;
    localparam int BD = 32;
    localparam int FR = 6 * SD;

    logic clock = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    time_display_scan_if bus();

    time_display_scan #(
        .SCAN_DIV  (SD),
        .BLINK_DIV (BD)
    ) dut (
        .clock   (clock),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Active-high gfedcba patterns; the display is active-low.
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model: t = clock edges since reset release.
    int unsigned t = 0;
    int unsigned m_sel_t = 0;
    int m_sel = 0;
    int m_snap [3];
    int m_presc, m_idx, m_fld, m_v, m_disp, m_d;
    bit m_dash, m_blank;
    logic [5:0] exp_an = 6'h3F;
    logic [6:0] exp_seg = 7'h7F;
    logic       exp_dp = 1'b1;

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            t = 0;
            m_sel = 0;
            exp_an = 6'h3F;
            exp_seg = 7'h7F;
            exp_dp = 1'b1;
        end else begin
            t++;
            if (t == 1 || t % FR == 0) begin
                m_snap[0] = int'(bus.count_sec);
                m_snap[1] = int'(bus.count_min);
                m_snap[2] = int'(bus.count_hour);
            end
            if (!bus.load) m_sel = 0;
            else if (bus.setting3) begin m_sel = 3; m_sel_t = t; end
            else if (bus.setting2) begin m_sel = 2; m_sel_t = t; end
            else if (bus.setting1) begin m_sel = 1; m_sel_t = t; end
            m_presc = int'(t % SD);
            m_idx = int'((t / SD) % 6);
            m_fld = m_idx / 2;
            m_v = m_snap[m_fld];
            m_dash = m_v > ((m_fld == 2) ? 23 : 59);
            m_disp = m_v;
`ifdef DISP_12H_EN
            if (m_fld == 2) m_disp = (m_v % 12 == 0) ? 12 : m_v % 12;
`endif
            m_d = (m_idx % 2 == 1) ? m_disp / 10 : m_disp % 10;
            if (m_dash) exp_seg = 7'h3F;
            else exp_seg = ~seg_tab[m_d];
            m_blank = (m_sel == m_fld + 1) &&
                      (((t - m_sel_t) / BD) % 2 == 1);
            exp_an = 6'h3F;
            if (m_presc != 0 && !m_blank) exp_an[m_idx] = 1'b0;
            exp_dp = !(m_idx == 2 || m_idx == 4);
`ifdef DISP_12H_EN
            if (m_idx == 5 && !m_dash && m_v >= 12) exp_dp = 1'b0;
`endif
        end
    end

    task automatic set_time(input int s, input int m, input int h);
        bus.count_sec = 6'(s);
        bus.count_min = 6'(m);
        bus.count_hour = 6'(h);
    endtask

    task automatic test_reset();
        @(negedge clock);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.an_n, bus.seg_n, bus.dp_n} !== {6'h3F, 7'h7F, 1'b1}) begin
            failures++;
            $display("FAIL reset_assert got an=%h seg=%h dp=%b want 3f 7f 1",
                     bus.an_n, bus.seg_n, bus.dp_n);
        end
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({bus.an_n, bus.seg_n, bus.dp_n} !== {6'h3F, 7'h7F, 1'b1}) begin
            failures++;
            $display("FAIL reset_release got an=%h seg=%h dp=%b want 3f 7f 1",
                     bus.an_n, bus.seg_n, bus.dp_n);
        end
    endtask

    task automatic test_scan_pattern();
        int dig [6] = '{6, 5, 4, 3, 2, 1};
        int s;
        logic [5:0] w_an;
        logic [6:0] w_seg;
        logic w_dp;
        repeat (2 * FR) begin
            @(negedge clock);
            checks++;
            if ({bus.an_n, bus.seg_n, bus.dp_n} !==
                {exp_an, exp_seg, exp_dp}) begin
                failures++;
                $display("FAIL scan t=%0d got %h/%h/%b want %h/%h/%b", t,
                         bus.an_n, bus.seg_n, bus.dp_n,
                         exp_an, exp_seg, exp_dp);
            end
            if (t % SD == 1) begin
                s = int'((t / SD) % 6);
                w_an = ~(6'd1 << s);
                w_seg = ~seg_tab[dig[s]];
                w_dp = !(s == 2 || s == 4);
`ifdef DISP_12H_EN
                if (s == 5) w_dp = 1'b0;
`endif
                checks++;
                if ({bus.an_n, bus.seg_n, bus.dp_n} !==
                    {w_an, w_seg, w_dp}) begin
                    failures++;
                    $display("FAIL digit%0d got %h/%h/%b want %h/%h/%b", s,
                             bus.an_n, bus.seg_n, bus.dp_n, w_an, w_seg, w_dp);
                end
            end
        end
    endtask

    task automatic test_snapshot();
        int unsigned t_end;
        logic [6:0] w_seg;
        int guard = 0;
        while (!((t / SD) % 6 == 1 && t % SD == 2) && guard < 2 * FR) begin
            @(negedge clock);
            guard++;
        end
        checks++;
        if (guard >= 2 * FR) begin
            failures++;
            $display("FAIL snap_align got t=%0d want slot 1", t);
        end
        set_time(57, 35, 13);
        t_end = (t / FR + 1) * FR;
        repeat (2 * FR) begin
            @(negedge clock);
            checks++;
            if ({bus.an_n, bus.seg_n, bus.dp_n} !==
                {exp_an, exp_seg, exp_dp}) begin
                failures++;
                $display("FAIL snapshot t=%0d got %h/%h/%b want %h/%h/%b", t,
                         bus.an_n, bus.seg_n, bus.dp_n,
                         exp_an, exp_seg, exp_dp);
            end
            if ((t / SD) % 6 == 2 && t % SD == 1) begin
                w_seg = ~seg_tab[(t < t_end) ? 4 : 5];
                checks++;
                if (bus.seg_n !== w_seg) begin
                    failures++;
                    $display("FAIL snap_min t=%0d got %h want %h",
                             t, bus.seg_n, w_seg);
                end
            end
        end
    endtask

    task automatic test_random_frames();
        int k;
        for (int it = 0; it < 8; it++) begin
            k = int'($urandom_range(FR - 1, 0));
            for (int i = 0; i < FR; i++) begin
                @(negedge clock);
                checks++;
                if ({bus.an_n, bus.seg_n, bus.dp_n} !==
                    {exp_an, exp_seg, exp_dp}) begin
                    failures++;
                    $display("FAIL random t=%0d got %h/%h/%b want %h/%h/%b",
                             t, bus.an_n, bus.seg_n, bus.dp_n,
                             exp_an, exp_seg, exp_dp);
                end
                if (i == k)
                    set_time(int'($urandom_range(59, 0)),
                             int'($urandom_range(59, 0)),
                             int'($urandom_range(23, 0)));
            end
        end
    endtask

    task automatic test_hours();
        int hrs [6] = '{0, 1, 11, 12, 13, 23};
        for (int j = 0; j < 6; j++) begin
            set_time(int'($urandom_range(59, 0)),
                     int'($urandom_range(59, 0)), hrs[j]);
            repeat (2 * FR) begin
                @(negedge clock);
                checks++;
                if ({bus.an_n, bus.seg_n, bus.dp_n} !==
                    {exp_an, exp_seg, exp_dp}) begin
                    failures++;
                    $display("FAIL hour%0d t=%0d got %h/%h/%b want %h/%h/%b",
                             hrs[j], t, bus.an_n, bus.seg_n, bus.dp_n,
                             exp_an, exp_seg, exp_dp);
                end
            end
        end
    endtask

    task automatic test_dash();
        for (int j = 0; j < 4; j++) begin
            set_time(int'($urandom_range(59, 0)),
                     (j == 0) ? 60 : int'($urandom_range(63, 60)),
                     (j == 0) ? 24 : int'($urandom_range(63, 24)));
            repeat (2 * FR) begin
                @(negedge clock);
                checks++;
                if ({bus.an_n, bus.seg_n, bus.dp_n} !==
                    {exp_an, exp_seg, exp_dp}) begin
                    failures++;
                    $display("FAIL dash t=%0d got %h/%h/%b want %h/%h/%b",
                             t, bus.an_n, bus.seg_n, bus.dp_n,
                             exp_an, exp_seg, exp_dp);
                end
            end
        end
        set_time(56, 34, 12);
    endtask

    task automatic test_blink();
        bus.load = 1'b1;
        for (int i = 0; i < 4 * BD + 40; i++) begin
            @(negedge clock);
            checks++;
            if ({bus.an_n, bus.seg_n, bus.dp_n} !==
                {exp_an, exp_seg, exp_dp}) begin
                failures++;
                $display("FAIL blink t=%0d got %h/%h/%b want %h/%h/%b",
                         t, bus.an_n, bus.seg_n, bus.dp_n,
                         exp_an, exp_seg, exp_dp);
            end
            bus.setting2 = (i == 2);
            if (i == 4 * BD + 10) bus.load = 1'b0;
        end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 260; i++) begin
            @(negedge clock);
            checks++;
            if ({bus.an_n, bus.seg_n, bus.dp_n} !==
                {exp_an, exp_seg, exp_dp}) begin
                failures++;
                $display("FAIL prio i=%0d got %h/%h/%b want %h/%h/%b",
                         i, bus.an_n, bus.seg_n, bus.dp_n,
                         exp_an, exp_seg, exp_dp);
            end
            bus.load = (i < 130) || (i >= 200);
            bus.setting1 = (i == 1) || (i == 42);
            bus.setting3 = (i == 1);
            bus.setting2 = (i == 150);
        end
        bus.load = 1'b0;
    endtask

    task automatic test_reset_midslot();
        bus.load = 1'b1;
        bus.setting1 = 1'b1;
        @(negedge clock);
        bus.setting1 = 1'b0;
        repeat (BD + 5) @(negedge clock);
        @(posedge clock);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.an_n, bus.seg_n, bus.dp_n} !== {6'h3F, 7'h7F, 1'b1}) begin
            failures++;
            $display("FAIL midslot_reset got %h/%h/%b want 3f/7f/1",
                     bus.an_n, bus.seg_n, bus.dp_n);
        end
        @(negedge clock);
        bus.load = 1'b0;
        set_time(9, 8, 23);
        rst_n = 1'b1;
        repeat (2 * FR) begin
            @(negedge clock);
            checks++;
            if ({bus.an_n, bus.seg_n, bus.dp_n} !==
                {exp_an, exp_seg, exp_dp}) begin
                failures++;
                $display("FAIL restart t=%0d got %h/%h/%b want %h/%h/%b",
                         t, bus.an_n, bus.seg_n, bus.dp_n,
                         exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    initial begin
        set_time(56, 34, 12);
        bus.load = 1'b0;
        bus.setting1 = 1'b0;
        bus.setting2 = 1'b0;
        bus.setting3 = 1'b0;
        test_reset();
        test_scan_pattern();
        test_snapshot();
        test_random_frames();
        test_hours();
        test_dash();
        test_blink();
        test_priority();
        test_reset_midslot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
